div_seq_param: RTL and testbench
================================

// Module: div_seq_param
// PURPOSE
//  Parametrised multi-cycle restoring divider; next generation of the team's 32-bit sequential divider.
//  Adds WIDTH generalisation, explicit start/busy/done handshake, divide-by-zero flag, optional signed mode.
//  Datapath arithmetic unit; host issues one division at a time and samples results on done.
// PARAMETERS
//  WIDTH     32   operand/result width in bits (>= 4)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous, active-low reset
//  start        in   1      request; sampled only when busy=0
//  dividend     in   WIDTH  numerator, captured on accepted start
//  divisor      in   WIDTH  denominator, captured on accepted start
//  signed_op    in   1      (DIV_SIGNED_EN only) 1 = two's-complement operation
//  busy         out  1      high from the edge after accepted start until the done cycle
//  done         out  1      one-cycle pulse; results valid in that cycle and held after it
//  quotient     out  WIDTH  result quotient
//  remainder    out  WIDTH  result remainder
//  div_by_zero  out  1      set with done when divisor==0; held with results
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; busy, done, div_by_zero = 0; quotient = remainder = 0; in-flight op discarded, no done.
//  States: IDLE -> NORM -> CALC -> FIN -> IDLE.
//  IDLE: start=1 at edge N -> capture operands (magnitudes in signed mode); state NORM; busy=1.
//  NORM (edge N+1): L1, L2 = MSB position+1 of dividend/divisor magnitudes (0 if zero).
//   - L2==0: quotient = all ones, remainder = captured dividend, div_by_zero=1 -> FIN.
//   - L1<L2: quotient=0, remainder=dividend -> FIN (covers dividend==0).
//   - else f=L1-L2; divisor <<= f; iter = f+1; quotient = 0 -> CALC.
//  CALC, per edge: if rem>=dsr {q=(q<<1)|1; rem-=dsr} else q=q<<1; dsr>>=1; iter-=1; iter reaches 0 -> FIN.
//  FIN: apply sign fix-up (signed), drive done=1 for exactly one cycle, busy=0, state -> IDLE.
//  Latency: done high in the cycle after edge N+2 (early exits) or N+f+3 (CALC path).
//  start while busy=1: ignored, not queued. start during the done cycle: accepted (state already IDLE-capable).
//  Operand inputs may change after acceptance without effect; results hold until the next done.
//  iter counter width $clog2(WIDTH+1); all subtraction is WIDTH-bit unsigned on magnitudes.
// CONFIGURATION
//  DIV_SIGNED_EN defined: signed_op port exists; signed_op=1 -> quotient sign = sign(dividend) XOR sign(divisor),
//   remainder sign = sign(dividend) (truncating division); MIN/-1 -> quotient=MIN, remainder=0 (wrap);
//   divide by zero -> quotient all ones, remainder = dividend (original signed value), div_by_zero=1.
//  DIV_SIGNED_EN undefined: no signed_op port, unsigned only; fix-up logic absent.
// STRUCTURE
//  Package div_pkg: state enum (IDLE, NORM, CALC, FIN), localparam CNT_W function of WIDTH.
//  Sub-module div_lzc #(WIDTH): combinational MSB-position (leading-one) encoder, instantiated twice in NORM.
//  Top holds FSM, operand/result registers, iteration counter, sign fix-up.
// TESTING
//  1. WIDTH=32, 100/7 -> q=14, r=2, div_by_zero=0; f=4, done after edge N+7, busy high N+1..N+6.
//  2. 5/0 -> q=32'hFFFFFFFF, r=5, div_by_zero=1, done after edge N+2.
//  3. 3/10 -> q=0, r=3, done after edge N+2; 0/9 -> q=0, r=0, same latency.
//  4. 32'hFFFFFFFF/1 -> q=32'hFFFFFFFF, r=0, f=31, done after edge N+34; start pulses during busy ignored.
//  5. DIV_SIGNED_EN, signed_op=1: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; 32'h80000000/-1 -> q=32'h80000000, r=0.
//  6. reset=0 mid-CALC -> outputs 0 immediately, no done; next start 100/7 completes correctly.

Source files
------------

// File: rtl/div_seq_param_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    CALC = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Counter must hold WIDTH itself (shift of WIDTH-1 plus one final step).
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// Host <-> divider handshake bundle. The signed_op request bit exists only
// when DIV_SIGNED_EN is defined.
interface div_seq_param_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
`ifdef DIV_SIGNED_EN
    output signed_op,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef DIV_SIGNED_EN
    input  signed_op,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_seq_param_lzc.sv
// Leading-one position encoder: returns index of the highest set bit plus one,
// or zero for an all-zero input.
module div_lzc
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]        val_i,
  output logic [cnt_w(WIDTH)-1:0] pos_o
);

  localparam int CNT_W = cnt_w(WIDTH);

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (val_i[i]) pos_o = CNT_W'(i + 1);
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider with start/busy/done handshake and divide-by-zero
// flag. Define DIV_SIGNED_EN to add the signed_op request and sign fix-up.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_param_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);
  typedef logic [WIDTH-1:0] word_t;

  state_e           state_q, state_d;
  word_t            rem_q, rem_d;
  word_t            dsr_q, dsr_d;
  word_t            quo_q, quo_d;
  word_t            dvd_q, dvd_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             dbz_q, dbz_d;
  word_t            quot_res_q, quot_res_d;
  word_t            rem_res_q, rem_res_d;
  logic             dbz_res_q, dbz_res_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] l1, l2, shamt;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic sd, ss;

  assign sd = bus.signed_op & bus.dividend[WIDTH-1];
  assign ss = bus.signed_op & bus.divisor[WIDTH-1];
`endif

  // Two's-complement negate when requested; MIN maps to itself, which is the
  // correct unsigned magnitude of MIN.
  function automatic word_t cond_neg(input word_t v, input logic neg);
    return neg ? word_t'(-v) : v;
  endfunction

  div_lzc #(.WIDTH(WIDTH)) u_lzc_dvd (.val_i(rem_q), .pos_o(l1));
  div_lzc #(.WIDTH(WIDTH)) u_lzc_dsr (.val_i(dsr_q), .pos_o(l2));

  assign shamt = l1 - l2;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    quo_d      = quo_q;
    dvd_d      = dvd_q;
    iter_d     = iter_q;
    dbz_d      = dbz_q;
    quot_res_d = quot_res_q;
    rem_res_d  = rem_res_q;
    dbz_res_d  = dbz_res_q;
    done_d     = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = NORM;
          dvd_d   = bus.dividend;
          dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
          rem_d   = cond_neg(bus.dividend, sd);
          dsr_d   = cond_neg(bus.divisor, ss);
          qneg_d  = sd ^ ss;
          rneg_d  = sd;
`else
          rem_d   = bus.dividend;
          dsr_d   = bus.divisor;
`endif
        end
      end
      NORM: begin
        quo_d = '0;
        if (l2 == '0) begin
          dbz_d   = 1'b1;
          state_d = FIN;
        end else if (l1 < l2) begin
          state_d = FIN;
        end else begin
          // Align divisor MSB with dividend MSB so only f+1 steps are needed.
          dsr_d   = dsr_q << shamt;
          iter_d  = shamt + CNT_W'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (rem_q >= dsr_q) begin
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
          rem_d = rem_q - dsr_q;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        dsr_d  = dsr_q >> 1;
        iter_d = iter_q - CNT_W'(1);
        if (iter_q == CNT_W'(1)) state_d = FIN;
      end
      FIN: begin
        done_d    = 1'b1;
        state_d   = IDLE;
        dbz_res_d = dbz_q;
        if (dbz_q) begin
          quot_res_d = '1;
          rem_res_d  = dvd_q;
        end else begin
`ifdef DIV_SIGNED_EN
          quot_res_d = cond_neg(quo_q, qneg_q);
          rem_res_d  = cond_neg(rem_q, rneg_q);
`else
          quot_res_d = quo_q;
          rem_res_d  = rem_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible results: cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dbz_q      <= 1'b0;
      done_q     <= 1'b0;
      quot_res_q <= '0;
      rem_res_q  <= '0;
      dbz_res_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dbz_q      <= dbz_d;
      done_q     <= done_d;
      quot_res_q <= quot_res_d;
      rem_res_q  <= rem_res_d;
      dbz_res_q  <= dbz_res_d;
    end
  end

  // Working datapath: always reloaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dsr_q  <= dsr_d;
    quo_q  <= quo_d;
    dvd_q  <= dvd_d;
    iter_q <= iter_d;
`ifdef DIV_SIGNED_EN
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
`endif
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_res_q;
  assign bus.remainder   = rem_res_q;
  assign bus.div_by_zero = dbz_res_q;

endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param (WIDTH=32): directed cases, randomized
// back-to-back operations against an arithmetic reference, reset mid-operation.
module tb_div_seq_param;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  div_seq_param_if #(.WIDTH(W)) bus();

  div_seq_param #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  function automatic int bitlen(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic sg);
    return (sg && v[31]) ? 32'(-v) : v;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic sg);
    int la, lb;
    la = bitlen(mag(a, sg));
    lb = bitlen(mag(b, sg));
    if (b == 0 || la < lb) return 2;
    return la - lb + 3;
  endfunction

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    dz = (b == 0);
    if (b == 0) begin
      q = '1; r = a;
    end else if (!sg) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input bit poke, input int elat,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output bit busy_ok, output bit hold_ok);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIV_SIGNED_EN
    bus.signed_op = sg;
`endif
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
`ifdef DIV_SIGNED_EN
    bus.signed_op = 1'($urandom);
`endif
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    if (!bus.busy) busy_ok = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.quotient !== prev_q || bus.remainder !== prev_r) hold_ok = 1'b0;
      if (poke) bus.start = (c < elat - 1) ? 1'($urandom) : 1'b0;
    end
    bus.start = 1'b0;
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    prev_q = q;
    prev_r = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta[5] = '{32'd100, 32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] tb[5] = '{32'd7, 32'd0, 32'd10, 32'd9, 32'd1};
    logic [31:0] tq[5] = '{32'd14, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] tr[5] = '{32'd2, 32'd5, 32'd3, 32'd0, 32'd0};
    logic        tz[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int          tl[5] = '{7, 2, 2, 2, 34};
    logic [31:0] q, r; logic dz; int lat; bit bok, hok;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b0, (i == 4), tl[i], q, r, dz, lat, bok, hok);
      checks++;
      if (q !== tq[i] || r !== tr[i] || dz !== tz[i]) begin
        errors++;
        $display("FAIL dir_result%0d got q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 i, q, r, dz, tq[i], tr[i], tz[i]);
      end
      checks++;
      if (lat !== tl[i]) begin
        errors++;
        $display("FAIL dir_latency%0d got %0d required %0d", i, lat, tl[i]);
      end
      checks++;
      if (!bok || !hok) begin
        errors++;
        $display("FAIL dir_busy_hold%0d busy_ok=%0d hold_ok=%0d required 1 1", i, bok, hok);
      end
    end
    // Pulse ends, results persist, nothing queued from the ignored starts.
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 32'hFFFF_FFFF) begin
        errors++;
        $display("FAIL after_done done=%b busy=%b q=%h required 0 0 ffffffff",
                 bus.done, bus.busy, bus.quotient);
      end
    end
  endtask

  task automatic test_back_to_back(input bit signed_mode, input int n);
    logic [31:0] a, b, q, r, eq, er; logic dz, edz, sg; int lat, el; bit bok, hok;
    for (int i = 0; i < n; i++) begin
      a  = $urandom >> $urandom_range(0, 31);
      b  = (i % 9 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      sg = signed_mode ? 1'($urandom) : 1'b0;
      model(a, b, sg, eq, er, edz);
      el = exp_lat(a, b, sg);
      run_op(a, b, sg, 1'b1, el, q, r, dz, lat, bok, hok);
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL rand_result a=%h b=%h s=%b got q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 a, b, sg, q, r, dz, eq, er, edz);
      end
      checks++;
      if (lat !== el || !bok || !hok) begin
        errors++;
        $display("FAIL rand_timing a=%h b=%h got lat=%0d busy_ok=%0d hold_ok=%0d required lat=%0d 1 1",
                 a, b, lat, bok, hok, el);
      end
    end
  endtask

  task automatic test_reset_midcalc();
    logic [31:0] q, r; logic dz; int lat; bit bok, hok, saw_done;
    bus.start = 1'b1; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd1;
`ifdef DIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 67'd0) begin
      errors++;
      $display("FAIL midcalc_reset busy=%b done=%b dbz=%b q=%h r=%h required all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk); reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midcalc_discard got done/busy after reset required none");
    end
    prev_q = '0; prev_r = '0;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, 7, q, r, dz, lat, bok, hok);
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || dz !== 1'b0 || lat !== 7) begin
      errors++;
      $display("FAIL post_reset_op got q=%0d r=%0d dbz=%b lat=%0d required q=14 r=2 dbz=0 lat=7",
               q, r, dz, lat);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] tb[4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] tq[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tr[4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFB};
    logic        tz[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] q, r; logic dz; int lat; bit bok, hok;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b1, 1'b0, exp_lat(ta[i], tb[i], 1'b1), q, r, dz, lat, bok, hok);
      checks++;
      if (q !== tq[i] || r !== tr[i] || dz !== tz[i] || lat !== exp_lat(ta[i], tb[i], 1'b1)) begin
        errors++;
        $display("FAIL signed%0d got q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b",
                 i, q, r, dz, lat, tq[i], tr[i], tz[i]);
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(1'b0, 40);
    test_reset_midcalc();
`ifdef DIV_SIGNED_EN
    test_signed();
    test_back_to_back(1'b1, 30);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
